// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - shared sizes, FSM state encoding and test pattern for ram_bist
package ram_bist_pkg;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 4;
  localparam int DEPTH   = 16;
  localparam int PAT_MUL = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Expected cell content: (PAT_MUL*addr + seed), truncated to DATA_W bits
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] seed);
    return DATA_W'(addr) * DATA_W'(PAT_MUL) + seed;
  endfunction

endpackage

// File: rtl/ram_bist_chk.sv
// rtl/ram_bist_chk.sv - readback compare, error count and first failing address
module ram_bist_chk
  import ram_bist_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] rdata,
  output logic [4:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [4:0]        err_next
);

  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic              miss;

  // Align the address with the data the RAM returns RD_LAT cycles later
  generate
    if (RD_LAT == 0) begin : g_comb
      assign cmp_valid = valid;
      assign cmp_addr  = addr;
    end else begin : g_reg
      logic              valid_q;
      logic [ADDR_W-1:0] addr_q;

      // One-cycle delay of the read request to match the registered RAM output
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          addr_q  <= '0;
        end else begin
          valid_q <= valid;
          addr_q  <= addr;
        end
      end

      assign cmp_valid = valid_q;
      assign cmp_addr  = addr_q;
    end
  endgenerate

  assign miss     = cmp_valid && (rdata != pattern(cmp_addr, seed));
  // Count after this cycle's compare; lets the FSM grade the pass on the same edge
  assign err_next = err_count + 5'(miss);

  // Error tracking: cleared at pass start, first address latched on the first miss only
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (miss) begin
      err_count <= err_next;
      if (err_count == 5'd0) begin
        first_err_addr <= cmp_addr;
      end
    end
  end

endmodule

// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - 16x4 RAM write/readback self-test controller
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [DATA_W-1:0] seed_q;
  logic [ADDR_W-1:0] next_addr;
  logic              accept;
  logic              read_phase;
  logic [4:0]        err_next;

  assign next_addr  = ram_addr + 1'b1;
  assign accept     = (state == ST_IDLE) && start;
  assign read_phase = (state == ST_READ);

  ram_bist_chk #(.RD_LAT(RD_LAT)) u_chk (
    .clk            (clk),
    .rst            (rst),
    .clr            (accept),
    .valid          (read_phase),
    .addr           (ram_addr),
    .seed           (seed_q),
    .rdata          (ram_rdata),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .err_next       (err_next)
  );

  // Sequencer: write all cells, read them back, wait out read latency, report
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      seed_q    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_WRITE;
            seed_q    <= seed;
            busy      <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= pattern(ADDR_W'(0), seed);
          end
        end
        ST_WRITE: begin
          if (ram_addr == LAST_ADDR) begin
            state     <= ST_READ;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
          end else begin
            ram_addr  <= next_addr;
            ram_wdata <= pattern(next_addr, seed_q);
          end
        end
        ST_READ: begin
          if (ram_addr == LAST_ADDR) begin
            ram_addr <= '0;
            if (RD_LAT == 0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= (err_next == 5'd0);
            end else begin
              state <= ST_DRAIN;
            end
          end else begin
            ram_addr <= next_addr;
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_next == 5'd0);
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// tb/tb_ram_bist.sv - self-checking bench for ram_bist against a 16x4 registered-read RAM
module tb_ram_bist;

  localparam int RD_LAT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] seed;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic [3:0] first_err_addr;
  logic       ram_we;
  logic [3:0] ram_addr, ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_bist #(.RD_LAT(RD_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata)
  );

  // ram16x4: synchronous write, registered read
  logic [3:0] mem [16];
  logic [3:0] rd_q;
  logic [3:0] addr_q;
  logic [3:0] corrupt [16];
  logic       zero_rd;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd_q   <= mem[ram_addr];
    addr_q <= ram_addr;
  end

  assign ram_rdata = zero_rd ? 4'h0 : (rd_q ^ corrupt[addr_q]);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pat(input int a, input int s);
    return (3 * a + s) % 16;
  endfunction

  task automatic clear_corrupt();
    for (int i = 0; i < 16; i++) corrupt[i] = 4'h0;
    zero_rd = 1'b0;
  endtask

  task automatic run_pass(input logic [3:0] s, input int repulse_at, input string tag);
    int wa[$];
    int wd[$];
    int wc[$];
    int ndone, done_cyc, ok, exp_e, exp_f, want, got;
    logic busy1, pass_d, busy_d;
    ndone = 0; done_cyc = 0; busy1 = 1'b0; pass_d = 1'b0; busy_d = 1'b1;
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (c == 1) busy1 = busy;
      if (ram_we) begin
        wa.push_back(int'(ram_addr));
        wd.push_back(int'(ram_wdata));
        wc.push_back(c);
      end
      if (done) begin
        ndone++;
        if (done_cyc == 0) begin
          done_cyc = c;
          pass_d   = pass;
          busy_d   = busy;
        end
      end
      start = (repulse_at > 0) && ((c == repulse_at) || (done == 1'b1));
    end
    start = 1'b0;
    seed  = $urandom_range(0, 15);

    exp_e = 0; exp_f = 0;
    for (int a = 0; a < 16; a++) begin
      want = pat(a, int'(s));
      got  = zero_rd ? 0 : (want ^ int'(corrupt[a]));
      if (got != want) begin
        if (exp_e == 0) exp_f = a;
        exp_e++;
      end
    end
    ok = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] == i && wd[i] == pat(i, int'(s)) && wc[i] == i + 1) ok++;

    check({tag, ".busy_start"}, busy1, 1);
    check({tag, ".latency"}, done_cyc, 33 + RD_LAT);
    check({tag, ".done_count"}, ndone, 1);
    check({tag, ".write_count"}, wa.size(), 16);
    check({tag, ".write_seq"}, ok, 16);
    check({tag, ".mem0"}, mem[0], pat(0, int'(s)));
    check({tag, ".mem15"}, mem[15], pat(15, int'(s)));
    check({tag, ".busy_done"}, busy_d, 0);
    check({tag, ".pass_done"}, pass_d, (exp_e == 0));
    check({tag, ".err_count"}, err_count, exp_e);
    check({tag, ".first_err"}, first_err_addr, exp_f);
    check({tag, ".pass_hold"}, pass, (exp_e == 0));
    check({tag, ".idle_busy"}, busy, 0);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; seed = 4'h0;
    clear_corrupt();
    repeat (3) @(posedge clk);
    #1;
    check("reset.outputs",
          {busy, done, pass, err_count, first_err_addr, ram_we, ram_addr, ram_wdata}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_pass(4'h0, 0, "seed0");
    run_pass(4'hA, 0, "seedA");

    corrupt[5] = 4'h1;
    run_pass(4'h0, 0, "flip5");
    clear_corrupt();

    zero_rd = 1'b1;
    run_pass(4'h0, 0, "zero_rd");
    clear_corrupt();

    run_pass(4'h3, 5, "repulse");

    // abort in the 8th WRITE cycle, right after a passing run left pass=1
    @(negedge clk);
    seed  = 4'h6;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("abort.we_before", ram_we, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.outputs",
          {busy, done, pass, err_count, first_err_addr, ram_we, ram_addr, ram_wdata}, 0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy || ram_we) ndone++;
    end
    check("abort.no_activity", ndone, 0);
    run_pass(4'h6, 0, "after_abort");

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++)
        corrupt[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      run_pass(4'($urandom_range(0, 15)), 0, $sformatf("rand%0d", r));
      clear_corrupt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
